// File: rtl/hazard_ctrl.sv
// ID-stage hazard unit: tracks EX/MEM/WB destinations, raises load-use and MUL stalls,
// flushes IF/ID on taken control transfers and selects operand forwarding sources.
module hazard_ctrl #(
    parameter int MUL_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       use_rs_id,
    input  logic       use_rt_id,
    input  logic       write_id,
    input  logic [4:0] waddr_id,
    input  logic       is_lw_id,
    input  logic       is_mul_id,
    input  logic       is_jump,
    output logic       stall_pc,
    output logic       stall_if_id,
    output logic       bubble_id_ex,
    output logic       stall_ex,
    output logic       flush_if_id,
    output logic [1:0] fwd_rs,
    output logic [1:0] fwd_rt,
    output logic       mul_busy
);
    localparam int MW = $clog2(MUL_LAT) + 1;
    localparam logic [MW-1:0] MUL_INIT = MW'(MUL_LAT - 1);

    typedef struct packed {
        logic       valid;
        logic       write;
        logic [4:0] waddr;
        logic       is_lw;
        logic       is_mul;
    } ex_trk_t;

    typedef struct packed {
        logic       valid;
        logic       write;
        logic [4:0] waddr;
        logic       is_lw;
    } trk_t;

    ex_trk_t       ex_q, ex_d;
    trk_t          mem_q, mem_d, wb_q;
    logic [MW-1:0] mcnt_q, mcnt_d;

    function automatic logic hit(input logic v, input logic w, input logic [4:0] wa,
                                 input logic [4:0] r, input logic u, input logic idv);
        return idv & v & w & (wa == r) & (r != 5'd0) & u;
    endfunction

    // An EX hit that cannot be forwarded yet pins the select to the regfile; a stall covers it.
    function automatic logic [1:0] fsel(input logic h_ex, input logic ex_ok,
                                        input logic h_mem, input logic h_wb);
        if (h_ex)       return ex_ok ? 2'b01 : 2'b00;
        else if (h_mem) return 2'b10;
        else if (h_wb)  return 2'b11;
        else            return 2'b00;
    endfunction

    logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
    logic load_use, mul_stall, stall_any, ex_fwd_ok;
    logic [1:0] fwd_rs_c, fwd_rt_c;

    always_comb begin
        ex_rs  = hit(ex_q.valid,  ex_q.write,  ex_q.waddr,  rs_id, use_rs_id, id_valid);
        ex_rt  = hit(ex_q.valid,  ex_q.write,  ex_q.waddr,  rt_id, use_rt_id, id_valid);
        mem_rs = hit(mem_q.valid, mem_q.write, mem_q.waddr, rs_id, use_rs_id, id_valid);
        mem_rt = hit(mem_q.valid, mem_q.write, mem_q.waddr, rt_id, use_rt_id, id_valid);
        wb_rs  = hit(wb_q.valid,  wb_q.write,  wb_q.waddr,  rs_id, use_rs_id, id_valid);
        wb_rt  = hit(wb_q.valid,  wb_q.write,  wb_q.waddr,  rt_id, use_rt_id, id_valid);

        mul_stall = (mcnt_q != '0);
        load_use  = (ex_rs | ex_rt) & ex_q.is_lw;
        stall_any = load_use | mul_stall;
        ex_fwd_ok = ~ex_q.is_lw & ~mul_stall;
        fwd_rs_c  = fsel(ex_rs, ex_fwd_ok, mem_rs, wb_rs);
        fwd_rt_c  = fsel(ex_rt, ex_fwd_ok, mem_rt, wb_rt);
    end

    always_comb begin
        mcnt_d = mcnt_q;
        if (mul_stall)
            mcnt_d = mcnt_q - MW'(1);
        else if (id_valid & is_mul_id & ~load_use)
            mcnt_d = MUL_INIT;

        mem_d = '0;
        if (!mul_stall)
            mem_d = '{valid: ex_q.valid, write: ex_q.write, waddr: ex_q.waddr, is_lw: ex_q.is_lw};

        ex_d = ex_q;
        if (!mul_stall) begin
            if (load_use | ~id_valid)
                ex_d = '0;
            else
                ex_d = '{valid: 1'b1, write: write_id, waddr: waddr_id,
                         is_lw: is_lw_id, is_mul: is_mul_id};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q   <= '0;
            mem_q  <= '0;
            wb_q   <= '0;
            mcnt_q <= '0;
        end else begin
            ex_q   <= ex_d;
            mem_q  <= mem_d;
            wb_q   <= mem_q;
            mcnt_q <= mcnt_d;
        end
    end

    // WB load flag and the EX MUL flag are tracked for completeness; nothing downstream reads them here.
    logic unused_trk;
    assign unused_trk = wb_q.is_lw ^ ex_q.is_mul;

    // Outputs are forced low while reset is held, whatever the trackers contain.
    assign stall_pc     = ~rst & stall_any;
    assign stall_if_id  = ~rst & stall_any;
    assign bubble_id_ex = ~rst & load_use & ~mul_stall;
    assign stall_ex     = ~rst & mul_stall;
    assign mul_busy     = ~rst & mul_stall;
    assign flush_if_id  = ~rst & id_valid & is_jump & ~stall_any;
    assign fwd_rs       = rst ? 2'b00 : fwd_rs_c;
    assign fwd_rt       = rst ? 2'b00 : fwd_rt_c;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MUL_LAT=4); expected outputs go into a queue and a
// negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] rs_id, rt_id, waddr_id;
    logic       use_rs_id, use_rt_id, write_id, is_lw_id, is_mul_id, is_jump;
    logic       stall_pc, stall_if_id, bubble_id_ex, stall_ex, flush_if_id, mul_busy;
    logic [1:0] fwd_rs, fwd_rt;

    int tests = 0;
    int fails = 0;
    logic [9:0] exp_q[$];
    string      name_q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .write_id(write_id),
        .waddr_id(waddr_id), .is_lw_id(is_lw_id), .is_mul_id(is_mul_id), .is_jump(is_jump),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
        .stall_ex(stall_ex), .flush_if_id(flush_if_id), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
        .mul_busy(mul_busy)
    );

    // {stall_pc, stall_if_id, bubble_id_ex, stall_ex, flush_if_id, fwd_rs, fwd_rt, mul_busy}
    function automatic logic [9:0] E(input logic spc, input logic sif, input logic bub,
                                     input logic sex, input logic fl, input logic [1:0] frs,
                                     input logic [1:0] frt, input logic mb);
        return {spc, sif, bub, sex, fl, frs, frt, mb};
    endfunction

    // Drive one ID-stage vector, queue its expected response, advance to just past the next edge.
    task automatic cyc(input string nm, input logic r, input logic v,
                       input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                       input logic w, input logic [4:0] wa, input logic lw, input logic mul,
                       input logic j, input logic [9:0] exp);
        rst = r; id_valid = v; rs_id = rs; use_rs_id = urs; rt_id = rt; use_rt_id = urt;
        write_id = w; waddr_id = wa; is_lw_id = lw; is_mul_id = mul; is_jump = j;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [9:0] e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {stall_pc, stall_if_id, bubble_id_ex, stall_ex, flush_if_id, fwd_rs, fwd_rt, mul_busy};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL %s: got spc/sif/bub/sex/fl=%b fwd_rs=%b fwd_rt=%b mb=%b, want %b %b %b %b",
                         nm, a[9:5], a[4:3], a[2:1], a[0], e[9:5], e[4:3], e[2:1], e[0]);
            end
        end
    end

    initial begin
        rst = 1'b1; id_valid = 1'b0; rs_id = '0; rt_id = '0; waddr_id = '0;
        use_rs_id = 1'b0; use_rt_id = 1'b0; write_id = 1'b0; is_lw_id = 1'b0;
        is_mul_id = 1'b0; is_jump = 1'b0;
        @(posedge clk);
        #1;
        //   name          rst v  rs  urs rt  urt w  wa  lw mul j   expected
        cyc("rst_jump",    1, 1, 5'd3, 1, 5'd4, 1, 1, 5'd3, 0, 0, 1, E(0,0,0,0,0,0,0,0));
        cyc("rst_mul",     1, 1, 5'd3, 1, 5'd4, 1, 1, 5'd5, 0, 1, 0, E(0,0,0,0,0,0,0,0));
        // load-use
        cyc("lw8_issue",   0, 1, 5'd2, 1, 5'd0, 0, 1, 5'd8, 1, 0, 0, E(0,0,0,0,0,0,0,0));
        cyc("lu_stall",    0, 1, 5'd8, 1, 5'd8, 1, 1, 5'd9, 0, 0, 0, E(1,1,1,0,0,0,0,0));
        cyc("lu_fwd_mem",  0, 1, 5'd8, 1, 5'd8, 1, 1, 5'd9, 0, 0, 0, E(0,0,0,0,0,2,2,0));
        // ALU chain on $3
        cyc("addu3",       0, 1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0, 0, E(0,0,0,0,0,0,0,0));
        cyc("fwd_ex_rt_nouse", 0, 1, 5'd3, 1, 5'd3, 0, 1, 5'd10, 0, 0, 0, E(0,0,0,0,0,1,0,0));
        cyc("fwd_mem_wb",  0, 1, 5'd3, 1, 5'd9, 1, 0, 5'd0, 0, 0, 0, E(0,0,0,0,0,2,3,0));
        cyc("fwd_wb_mem",  0, 1, 5'd3, 1, 5'd10, 1, 1, 5'd0, 0, 0, 0, E(0,0,0,0,0,3,2,0));
        cyc("reg0_nofwd",  0, 1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0, 0, 0, E(0,0,0,0,0,0,0,0));
        // MUL stall
        cyc("mul5_issue",  0, 1, 5'd1, 1, 5'd2, 1, 1, 5'd5, 0, 1, 0, E(0,0,0,0,0,0,0,0));
        cyc("mul_stall1",  0, 1, 5'd5, 1, 5'd5, 1, 1, 5'd6, 0, 0, 0, E(1,1,0,1,0,0,0,1));
        cyc("mul_stall2",  0, 1, 5'd5, 1, 5'd5, 1, 1, 5'd6, 0, 0, 0, E(1,1,0,1,0,0,0,1));
        cyc("mul_stall3",  0, 1, 5'd5, 1, 5'd5, 1, 1, 5'd6, 0, 0, 0, E(1,1,0,1,0,0,0,1));
        cyc("mul_fwd_ex",  0, 1, 5'd5, 1, 5'd5, 1, 1, 5'd6, 0, 0, 0, E(0,0,0,0,0,1,1,0));
        cyc("mul_fwd_mem", 0, 1, 5'd5, 1, 5'd6, 1, 0, 5'd0, 0, 0, 0, E(0,0,0,0,0,2,1,0));
        // taken branch after load
        cyc("lw7_issue",   0, 1, 5'd1, 1, 5'd0, 0, 1, 5'd7, 1, 0, 0, E(0,0,0,0,0,0,0,0));
        cyc("beq_stall",   0, 1, 5'd7, 1, 5'd6, 1, 0, 5'd0, 0, 0, 1, E(1,1,1,0,0,0,3,0));
        cyc("beq_flush",   0, 1, 5'd7, 1, 5'd6, 1, 0, 5'd0, 0, 0, 1, E(0,0,0,0,1,2,0,0));
        cyc("post_flush",  0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, E(0,0,0,0,0,0,0,0));
        // jumps
        cyc("j_flush",     0, 1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, E(0,0,0,0,1,0,0,0));
        cyc("j_invalid",   0, 0, 5'd7, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, E(0,0,0,0,0,0,0,0));
        // reset during MUL stall
        cyc("mul5b_issue", 0, 1, 5'd1, 1, 5'd2, 1, 1, 5'd5, 0, 1, 0, E(0,0,0,0,0,0,0,0));
        cyc("jr_mul_stall",0, 1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, E(1,1,0,1,0,0,0,1));
        cyc("rst_mid_mul", 1, 1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, E(0,0,0,0,0,0,0,0));
        cyc("after_rst",   0, 1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, E(0,0,0,0,1,0,0,0));
        // MUL stall beats a jump, flush fires when it clears
        cyc("mul5c_issue", 0, 1, 5'd1, 1, 5'd2, 1, 1, 5'd5, 0, 1, 0, E(0,0,0,0,0,0,0,0));
        cyc("jr_hold1",    0, 1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, E(1,1,0,1,0,0,0,1));
        cyc("jr_hold2",    0, 1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, E(1,1,0,1,0,0,0,1));
        cyc("jr_hold3",    0, 1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, E(1,1,0,1,0,0,0,1));
        cyc("jr_flush",    0, 1, 5'd5, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1, E(0,0,0,0,1,1,0,0));
        // id_valid gates hits
        cyc("lw4_fwd_mem", 0, 1, 5'd5, 1, 5'd0, 0, 1, 5'd4, 1, 0, 0, E(0,0,0,0,0,2,0,0));
        cyc("invalid_nohit", 0, 0, 5'd4, 1, 5'd4, 1, 0, 5'd0, 0, 0, 0, E(0,0,0,0,0,0,0,0));

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expected responses left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
